// File: rtl/frontend_ctrl_pkg.sv
// Shared constants for the RF front-end sequencer: bus addresses, FSM encoding, CTRL fields.
package frontend_ctrl_pkg;

    // Serial settings-bus addresses
    localparam logic [6:0] FR_FE_CTRL   = 7'd40;
    localparam logic [6:0] FR_FE_SETTLE = 7'd41;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BLANK  = 3'd1;
    localparam logic [2:0] ST_APPLY  = 3'd2;
    localparam logic [2:0] ST_LE     = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    // CTRL word bit positions (filter field starts right above the switch field)
    localparam int CTRL_SW_LSB  = 0;
    localparam int CTRL_VCO_BIT = 31;

endpackage

// File: rtl/frontend_ctrl_timer.sv
// Down-counter shared by the LE pulse and the settle interval.
// 'done' is high during the last clock of an interval that was loaded with N>=1.
module fe_settle_timer #(
    parameter int SETTLE_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                done
);

    logic [SETTLE_W-1:0] count;

    // Load on request, otherwise count down and hold at zero (never wraps)
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - {{(SETTLE_W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

    assign done = (count <= {{(SETTLE_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/frontend_ctrl.sv
// RF front-end sequencer: decodes CTRL/SETTLE writes, blanks rx_gate, applies switch and
// filter settings, optionally pulses VCO latch-enable, then waits the settle time.
module frontend_ctrl
    import frontend_ctrl_pkg::*;
#(
    parameter logic [6:0] ADDR       = FR_FE_CTRL,
    parameter int         NUM_SW     = 4,
    parameter int         FILT_W     = 2,
    parameter int         LE_WIDTH   = 4,
    parameter int         SETTLE_W   = 16,
    parameter int         SETTLE_RST = 1000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [6:0]        serial_addr,
    input  logic [31:0]       serial_data,
    input  logic              serial_strobe,
    output logic [NUM_SW-1:0] sw_out,
    output logic [FILT_W-1:0] filt_out,
    output logic              vco_le,
    output logic              rx_gate,
    output logic              busy,
    output logic [7:0]        retune_count
);

    localparam int CTRL_FILT_LSB = CTRL_SW_LSB + NUM_SW;

    logic                ctrl_hit;
    logic                settle_hit;
    logic [NUM_SW-1:0]   shadow_sw;
    logic [FILT_W-1:0]   shadow_filt;
    logic                shadow_vco;
    logic                act_vco;
    logic                pending;
    logic [2:0]          state;
    logic [SETTLE_W-1:0] settle_reg;

    logic [2:0]          state_nxt;
    logic                pending_nxt;
    logic [NUM_SW-1:0]   sw_nxt;
    logic [FILT_W-1:0]   filt_nxt;
    logic                act_vco_nxt;
    logic                vco_nxt;
    logic                gate_nxt;
    logic [7:0]          count_nxt;
    logic                tmr_load;
    logic [SETTLE_W-1:0] tmr_val;
    logic                tmr_done;

    assign ctrl_hit   = serial_strobe && (serial_addr == ADDR);
    assign settle_hit = serial_strobe && (serial_addr == (ADDR + 7'd1));

    fe_settle_timer #(.SETTLE_W(SETTLE_W)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Settings registers: CTRL shadow (last write wins) and settle length
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow_sw   <= '0;
            shadow_filt <= '0;
            shadow_vco  <= 1'b0;
            settle_reg  <= SETTLE_W'(SETTLE_RST);
        end else begin
            if (ctrl_hit) begin
                shadow_sw   <= serial_data[CTRL_SW_LSB +: NUM_SW];
                shadow_filt <= serial_data[CTRL_FILT_LSB +: FILT_W];
                shadow_vco  <= serial_data[CTRL_VCO_BIT];
            end
            if (settle_hit) begin
                settle_reg <= serial_data[SETTLE_W-1:0];
            end
        end
    end

    // Next-state and next-output decode; outputs change on entry into a state
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        sw_nxt      = sw_out;
        filt_nxt    = filt_out;
        act_vco_nxt = act_vco;
        vco_nxt     = 1'b0;
        gate_nxt    = 1'b0;
        count_nxt   = retune_count;
        tmr_load    = 1'b0;
        tmr_val     = settle_reg;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_nxt   = ST_BLANK;
                    pending_nxt = 1'b0;
                    gate_nxt    = 1'b0;
                end else begin
                    gate_nxt    = 1'b1;
                end
            end
            ST_BLANK: begin
                state_nxt   = ST_APPLY;
                sw_nxt      = shadow_sw;
                filt_nxt    = shadow_filt;
                act_vco_nxt = shadow_vco;
            end
            ST_APPLY: begin
                if (act_vco) begin
                    state_nxt = ST_LE;
                    vco_nxt   = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_W'(LE_WIDTH);
                end else if (settle_reg == '0) begin
                    state_nxt = ST_IDLE;
                    gate_nxt  = 1'b1;
                    count_nxt = retune_count + 8'd1;
                end else begin
                    state_nxt = ST_SETTLE;
                    tmr_load  = 1'b1;
                end
            end
            ST_LE: begin
                if (!tmr_done) begin
                    vco_nxt = 1'b1;
                end else if (settle_reg == '0) begin
                    state_nxt = ST_IDLE;
                    gate_nxt  = 1'b1;
                    count_nxt = retune_count + 8'd1;
                end else begin
                    state_nxt = ST_SETTLE;
                    tmr_load  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_nxt = ST_IDLE;
                    gate_nxt  = 1'b1;
                    count_nxt = retune_count + 8'd1;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gate_nxt  = 1'b1;
            end
        endcase
        // A CTRL write always queues a sequence, even while one is being started
        if (ctrl_hit) begin
            pending_nxt = 1'b1;
        end else begin
            pending_nxt = pending_nxt;
        end
    end

    // Sequencer state and registered outputs; reset aborts and drops queued writes
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pending      <= 1'b0;
            act_vco      <= 1'b0;
            sw_out       <= '0;
            filt_out     <= '0;
            vco_le       <= 1'b0;
            rx_gate      <= 1'b1;
            busy         <= 1'b0;
            retune_count <= 8'd0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            act_vco      <= act_vco_nxt;
            sw_out       <= sw_nxt;
            filt_out     <= filt_nxt;
            vco_le       <= vco_nxt;
            rx_gate      <= gate_nxt;
            busy         <= (state_nxt != ST_IDLE) | pending_nxt;
            retune_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_frontend_ctrl.sv
// Directed self-checking bench for frontend_ctrl.
module tb_frontend_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  serial_addr = 7'd0;
    logic [31:0] serial_data = 32'd0;
    logic        serial_strobe = 1'b0;
    logic [3:0]  sw_out;
    logic [1:0]  filt_out;
    logic        vco_le;
    logic        rx_gate;
    logic        busy;
    logic [7:0]  retune_count;

    int errors = 0;
    int checks = 0;
    int low_cnt;
    int vco_cnt;
    int vco_first;
    int sw_first;

    frontend_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .sw_out        (sw_out),
        .filt_out      (filt_out),
        .vco_le        (vco_le),
        .rx_gate       (rx_gate),
        .busy          (busy),
        .retune_count  (retune_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
        serial_addr   = a;
        serial_data   = d;
        serial_strobe = 1'b1;
        tick();
        serial_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Observe edges 1..n after a CTRL write at edge 0
    task automatic watch(input int n, input logic [3:0] exp_sw);
        low_cnt   = 0;
        vco_cnt   = 0;
        vco_first = -1;
        sw_first  = -1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (!rx_gate) low_cnt++;
            if (vco_le) begin
                vco_cnt++;
                if (vco_first < 0) vco_first = k;
            end
            if (sw_first < 0 && sw_out == exp_sw) sw_first = k;
        end
    endtask

    initial begin
        // 1. Reset state
        do_reset();
        check("rst_sw", sw_out, 32'h0);
        check("rst_filt", filt_out, 32'h0);
        check("rst_vco", vco_le, 32'h0);
        check("rst_gate", rx_gate, 32'h1);
        check("rst_busy", busy, 32'h0);
        check("rst_count", retune_count, 32'h0);

        // 2. SETTLE=5, CTRL=0x25, no VCO
        bus_write(7'd41, 32'd5);
        check("t2_settle_not_busy", busy, 32'h0);
        bus_write(7'd40, 32'h0000_0025);
        watch(30, 4'h5);
        check("t2_low_clocks", low_cnt, 32'd7);
        check("t2_sw_edge", sw_first, 32'd2);
        check("t2_vco_cnt", vco_cnt, 32'd0);
        check("t2_sw", sw_out, 32'h5);
        check("t2_filt", filt_out, 32'h2);
        check("t2_count", retune_count, 32'd1);
        check("t2_busy", busy, 32'h0);
        check("t2_gate", rx_gate, 32'h1);

        // 3. CTRL=0x8000_0003 with SETTLE=0
        do_reset();
        bus_write(7'd41, 32'd0);
        bus_write(7'd40, 32'h8000_0003);
        watch(20, 4'h3);
        check("t3_vco_cnt", vco_cnt, 32'd4);
        check("t3_vco_first", vco_first, 32'd3);
        check("t3_low_clocks", low_cnt, 32'd6);
        check("t3_sw", sw_out, 32'h3);
        check("t3_filt", filt_out, 32'h0);
        check("t3_count", retune_count, 32'd1);

        // 4. Writes during SETTLE are queued; last one wins
        do_reset();
        bus_write(7'd41, 32'd3);
        bus_write(7'd40, 32'h0000_0001);   // edge 0
        tick();
        tick();
        tick();                            // edge 3: SETTLE entered
        bus_write(7'd40, 32'h0000_0002);   // edge 4
        bus_write(7'd40, 32'h0000_003A);   // edge 5
        check("t4_no_abort_sw", sw_out, 32'h1);
        check("t4_no_abort_gate", rx_gate, 32'h0);
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            tick();
        end
        check("t4_busy_bound", busy, 32'h0);
        check("t4_sw", sw_out, 32'hA);
        check("t4_filt", filt_out, 32'h3);
        check("t4_count", retune_count, 32'd2);
        check("t4_gate", rx_gate, 32'h1);

        // 5. Reset in the middle of the LE pulse, with a write queued
        do_reset();
        bus_write(7'd41, 32'd10);
        bus_write(7'd40, 32'h8000_000F);   // edge 0
        tick();
        tick();
        tick();
        tick();                            // edge 4
        check("t5_in_le", vco_le, 32'h1);
        bus_write(7'd40, 32'h0000_0007);   // edge 5, queued
        reset_n = 1'b0;
        tick();
        check("t5_vco", vco_le, 32'h0);
        check("t5_gate", rx_gate, 32'h1);
        check("t5_sw", sw_out, 32'h0);
        check("t5_busy", busy, 32'h0);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("t5_no_replay_sw", sw_out, 32'h0);
        check("t5_no_replay_gate", rx_gate, 32'h1);
        check("t5_no_replay_busy", busy, 32'h0);
        check("t5_count", retune_count, 32'd0);

        // 6. 256 zero-settle sequences wrap the counter; other address ignored
        do_reset();
        bus_write(7'd41, 32'd0);
        for (int i = 0; i < 256; i++) begin
            bus_write(7'd40, 32'(i));
            tick();
            tick();
            tick();
            if (i == 254) check("t6_count_255", retune_count, 32'd255);
        end
        check("t6_wrap", retune_count, 32'd0);
        check("t6_sw_last", sw_out, 32'hF);
        check("t6_filt_last", filt_out, 32'h3);
        bus_write(7'd42, 32'h0000_0000);
        tick();
        tick();
        check("t6_other_busy", busy, 32'h0);
        check("t6_other_gate", rx_gate, 32'h1);
        check("t6_other_sw", sw_out, 32'hF);
        check("t6_other_count", retune_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
